exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception commit controller sitting directly upstream of the CP0 register block in the MEM/WB boundary of the five-stage MIPS pipeline. It samples raw exception and `eret` indications from the MEM stage and resolves them to a single cause. It then drives one-cycle flag pulses and the faulting PC into CP0, and sequences the pipeline flush and PC redirect to the exception vector or to EPC. It also synchronises external hardware interrupt lines and merges the CP0 timer interrupt into the 6-bit interrupt vector CP0 records in Cause.

## Interface
- `EXC_VECTOR`, default 32'hBFC00380: redirect target for every exception.
- `FLUSH_CYCLES`, default 1: number of cycles spent in FLUSH; legal range 1..15.
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_valid_i`  in  1  MEM stage holds a valid instruction.
- `mem_pc_i`  in  32  PC of the MEM-stage instruction.
- `mem_delayslot_i`  in  1  MEM instruction is in a branch delay slot.
- `mem_exc_i`  in  5  raw flags {break, syscall, overflow, ades, adel}.
- `mem_eret_i`  in  1  MEM instruction is `eret`.
- `stall_i`  in  1  pipeline stalled; new detection is inhibited.
- `wb_cp0_we_i`  in  1  in-flight `mtc0` in WB.
- `wb_cp0_waddr_i`  in  5  CP0 register address of that write.
- `wb_cp0_wdata_i`  in  32  data of that write.
- `cp0_epc_i`  in  32  current EPC from CP0.
- `timer_int_i`  in  1  timer interrupt from CP0.
- `hw_int_i`  in  6  asynchronous external interrupt lines.
- `int_o`  out  6  interrupt vector to CP0.
- `break_flag_o`, `syscall_flag_o`, `overflow_flag_o`, `ades_flag_o`, `adel_flag_o`, `eret_flag_o`  out  1 each  one-cycle pulses to CP0.
- `delayslot_flag_o`  out  1  delay-slot flag to CP0.
- `exc_pc_o`  out  32  faulting PC to CP0; the raw PC is passed, and CP0 applies the −4 itself.
- `flush_o`  out  1  flush IF through MEM.
- `redirect_o`  out  1  one-cycle PC load strobe.
- `redirect_pc_o`  out  32  PC load target.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, COMMIT, FLUSH, REDIRECT.
- **Detection (in IDLE only):**
  - Condition: `mem_valid_i && !stall_i && (|mem_exc_i || mem_eret_i)`.
  - On the next edge the block latches the winning cause, `mem_pc_i`, `mem_delayslot_i` and the target, then enters COMMIT.
- **Cause priority, fixed:** break > syscall > overflow > ades > adel > eret. Exactly one flag is asserted.
- **Target selection:**
  - Any exception: `EXC_VECTOR`.
  - `eret`: the EPC value at detection time; see Configuration.
- **COMMIT** lasts one cycle:
  - The selected flag is 1 and `exc_pc_o`/`delayslot_flag_o` are valid.
  - `flush_o` is 1.
  - For `eret`, only `eret_flag_o` is pulsed and `delayslot_flag_o` is 0.
  - Next state: FLUSH.
- **FLUSH** lasts exactly `FLUSH_CYCLES` cycles. `flush_o` is 1 and all flags are 0. A 4-bit down-counter tracks the cycles. Next state: REDIRECT.
- **REDIRECT** lasts one cycle. `redirect_o` is 1, `redirect_pc_o` holds the target and `flush_o` is 0. Next state: IDLE.
- **While `busy_o` is high**, `mem_*` and `stall_i` are ignored. A second exception arriving during a sequence is dropped, because the flush kills it.
- **Interrupts:**
  - `hw_int_i` passes through a 2-flop synchroniser per bit.
  - `int_o[4:0]` = sync[4:0].
  - `int_o[5]` = sync[5] | `timer_int_i`; the timer path is combinational.
  - Interrupt handling is independent of the FSM state.
- **Outputs outside their active state:** all flags, `flush_o`, `redirect_o` and `busy_o` are 0. `exc_pc_o` and `redirect_pc_o` hold their latched values.

## Timing
- **Reset values:** every output is 0; the state is IDLE, the synchronisers are 0 and the counter is 0.
- **Reset priority:** `rst` takes priority in any state, including mid-FLUSH. The block is in IDLE with all outputs 0 after that edge, and no redirect is issued.
- **Latency:** with detection sampled at edge N:
  - COMMIT occupies cycle N+1.
  - FLUSH occupies cycles N+2 .. N+1+`FLUSH_CYCLES`.
  - `redirect_o` is high in cycle N+2+`FLUSH_CYCLES`.
  - IDLE resumes the cycle after that.
- **Stall:** if `stall_i` is 1, detection is deferred. The MEM contents are held by the pipeline, and detection happens on the first edge where `stall_i` = 0.
- **Interrupt latency:** `hw_int_i` to `int_o` is 2 clock edges; `timer_int_i` to `int_o[5]` is 0 cycles.

## Configuration
- **`CP0_EPC_FWD_EN` defined:** the `eret` target is `wb_cp0_wdata_i` when `wb_cp0_we_i` is 1 and `wb_cp0_waddr_i` equals the EPC address (14) in the detection cycle. Otherwise it is `cp0_epc_i`.
- **`CP0_EPC_FWD_EN` undefined:** the target is always `cp0_epc_i`, the `wb_cp0_*` inputs are unused, and software must separate `mtc0 EPC` from `eret` by two instructions.

## Test plan
- **Syscall:** apply syscall at PC 0x80001000, not in a delay slot, `FLUSH_CYCLES`=1, detected at edge N. Required:
  - Cycle N+1: `syscall_flag_o`=1, `exc_pc_o`=0x80001000, `delayslot_flag_o`=0, `flush_o`=1.
  - Cycle N+2: `flush_o`=1.
  - Cycle N+3: `redirect_o`=1, `redirect_pc_o`=0xBFC00380.
- **Priority:** `mem_exc_i`=5'b11100 in a delay slot at PC 0x80000010. Required: only `break_flag_o` pulses, with `delayslot_flag_o`=1 and `exc_pc_o`=0x80000010.
- **`eret` with forwarding:** `cp0_epc_i`=0x80000000, WB writing reg 14 = 0x80002000. Required: `redirect_pc_o`=0x80002000 with `CP0_EPC_FWD_EN` defined, 0x80000000 without; `eret_flag_o` is the only flag.
- **Stall and busy:** hold `stall_i`=1 for 3 cycles with overflow pending. Required:
  - No flag while stalled.
  - COMMIT occurs 1 cycle after `stall_i` falls.
  - An adel presented during FLUSH produces no second sequence.
- **Interrupt:** raise `hw_int_i[2]`. Required: `int_o[2]`=1 after exactly 2 edges. `timer_int_i`=1 gives `int_o[5]`=1 in the same cycle.
- **Reset mid-sequence:** assert `rst` in FLUSH with `FLUSH_CYCLES`=4. Required: after that edge all outputs are 0, the state is IDLE, and `redirect_o` never pulses.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception commit controller: resolves MEM-stage exceptions/eret to one cause, pulses CP0 flags,
// sequences flush and PC redirect, and synchronises interrupts. Optional macro: CP0_EPC_FWD_EN.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_delayslot_i,
  input  logic [4:0]  mem_exc_i,
  input  logic        mem_eret_i,
  input  logic        stall_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        timer_int_i,
  input  logic [5:0]  hw_int_i,
  output logic [5:0]  int_o,
  output logic        break_flag_o,
  output logic        syscall_flag_o,
  output logic        overflow_flag_o,
  output logic        ades_flag_o,
  output logic        adel_flag_o,
  output logic        eret_flag_o,
  output logic        delayslot_flag_o,
  output logic [31:0] exc_pc_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, REDIRECT} state_t;

  localparam logic [4:0] EPC_ADDR   = 5'd14;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] target_reg;
  logic [5:0]  flags_reg;
  logic        delayslot_reg;
  logic [31:0] exc_pc_reg;
  logic        flush_reg;
  logic        redirect_reg;
  logic [31:0] redirect_pc_reg;
  logic        busy_reg;
  logic [5:0]  sync1_reg;
  logic [5:0]  sync2_reg;

  logic        detect;
  logic        any_exc;
  logic [5:0]  cause_next;
  logic [31:0] eret_target;

  assign any_exc = |mem_exc_i;
  assign detect  = mem_valid_i && !stall_i && (any_exc || mem_eret_i);

  // Flag order {break, syscall, overflow, ades, adel, eret}; mem_exc_i[4] is break.
  always_comb begin
    cause_next = 6'b000000;
    if (mem_exc_i[4])      cause_next = 6'b100000;
    else if (mem_exc_i[3]) cause_next = 6'b010000;
    else if (mem_exc_i[2]) cause_next = 6'b001000;
    else if (mem_exc_i[1]) cause_next = 6'b000100;
    else if (mem_exc_i[0]) cause_next = 6'b000010;
    else if (mem_eret_i)   cause_next = 6'b000001;
  end

`ifdef CP0_EPC_FWD_EN
  // An mtc0 EPC still in WB has not reached CP0 yet, so take its data directly.
  assign eret_target = (wb_cp0_we_i && (wb_cp0_waddr_i == EPC_ADDR)) ? wb_cp0_wdata_i : cp0_epc_i;
`else
  logic unused_wb;
  assign unused_wb   = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i, EPC_ADDR};
  assign eret_target = cp0_epc_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      target_reg      <= 32'd0;
      flags_reg       <= 6'd0;
      delayslot_reg   <= 1'b0;
      exc_pc_reg      <= 32'd0;
      flush_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= 32'd0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (detect) begin
            flags_reg     <= cause_next;
            delayslot_reg <= any_exc ? mem_delayslot_i : 1'b0;
            exc_pc_reg    <= mem_pc_i;
            target_reg    <= any_exc ? EXC_VECTOR : eret_target;
            flush_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= COMMIT;
          end
        end
        COMMIT: begin
          flags_reg     <= 6'd0;
          delayslot_reg <= 1'b0;
          cnt_reg       <= FLUSH_LAST;
          state_reg     <= FLUSH;
        end
        FLUSH: begin
          if (cnt_reg == 4'd0) begin
            flush_reg       <= 1'b0;
            redirect_reg    <= 1'b1;
            redirect_pc_reg <= target_reg;
            state_reg       <= REDIRECT;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        REDIRECT: begin
          redirect_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 6'd0;
      sync2_reg <= 6'd0;
    end else begin
      sync1_reg <= hw_int_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign int_o = {sync2_reg[5] | timer_int_i, sync2_reg[4:0]};

  assign {break_flag_o, syscall_flag_o, overflow_flag_o,
          ades_flag_o, adel_flag_o, eret_flag_o} = flags_reg;
  assign delayslot_flag_o = delayslot_reg;
  assign exc_pc_o         = exc_pc_reg;
  assign flush_o          = flush_reg;
  assign redirect_o       = redirect_reg;
  assign redirect_pc_o    = redirect_pc_reg;
  assign busy_o           = busy_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected commits/redirects are queued at stimulus time and
// compared when the DUT produces them. A second instance (FLUSH_CYCLES=4) covers reset mid-flush.
module tb_exc_ctrl;

  localparam int FC = 1;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst, rst4;
  logic mem_valid, v4, mem_delayslot, mem_eret, stall, wb_we, timer;
  logic [31:0] mem_pc, wb_wdata, cp0_epc;
  logic [4:0]  mem_exc, wb_waddr;
  logic [5:0]  hw_int;

  logic [5:0]  int_o, d4_int;
  logic        brk, sys, ovf, ades, adel, eret, ds, flush, redirect, busy;
  logic [31:0] exc_pc, redirect_pc;
  logic        d4_brk, d4_sys, d4_ovf, d4_ades, d4_adel, d4_eret, d4_ds, d4_flush, d4_redirect, d4_busy;
  logic [31:0] d4_exc_pc, d4_redirect_pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
    .mem_delayslot_i(mem_delayslot), .mem_exc_i(mem_exc), .mem_eret_i(mem_eret),
    .stall_i(stall), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr),
    .wb_cp0_wdata_i(wb_wdata), .cp0_epc_i(cp0_epc), .timer_int_i(timer),
    .hw_int_i(hw_int), .int_o(int_o), .break_flag_o(brk), .syscall_flag_o(sys),
    .overflow_flag_o(ovf), .ades_flag_o(ades), .adel_flag_o(adel), .eret_flag_o(eret),
    .delayslot_flag_o(ds), .exc_pc_o(exc_pc), .flush_o(flush), .redirect_o(redirect),
    .redirect_pc_o(redirect_pc), .busy_o(busy));

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4), .mem_valid_i(v4), .mem_pc_i(mem_pc),
    .mem_delayslot_i(mem_delayslot), .mem_exc_i(mem_exc), .mem_eret_i(mem_eret),
    .stall_i(stall), .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr),
    .wb_cp0_wdata_i(wb_wdata), .cp0_epc_i(cp0_epc), .timer_int_i(timer),
    .hw_int_i(hw_int), .int_o(d4_int), .break_flag_o(d4_brk), .syscall_flag_o(d4_sys),
    .overflow_flag_o(d4_ovf), .ades_flag_o(d4_ades), .adel_flag_o(d4_adel), .eret_flag_o(d4_eret),
    .delayslot_flag_o(d4_ds), .exc_pc_o(d4_exc_pc), .flush_o(d4_flush), .redirect_o(d4_redirect),
    .redirect_pc_o(d4_redirect_pc), .busy_o(d4_busy));

  typedef struct {
    logic [5:0]  flags;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] target;
    int          commit;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          commit;
    int          redir;
  } red_t;

  exp_t cq[$];
  red_t rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Flags {break, syscall, overflow, ades, adel, eret}; exceptions outrank eret.
  function automatic logic [5:0] exp_flags(input logic [4:0] exc, input logic er);
    for (int b = 4; b >= 0; b--)
      if (exc[b]) return 6'(1) << (b + 1);
    return er ? 6'b000001 : 6'b000000;
  endfunction

  function automatic logic [31:0] exp_target(input logic [4:0] exc, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [31:0] epc);
    if (exc != 5'd0) return VEC;
`ifdef CP0_EPC_FWD_EN
    if (we && wa == 5'd14) return wd;
`endif
    return epc;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [5:0] fl;
      fl = {brk, sys, ovf, ades, adel, eret};
      if (cq.size() > 0 && cyc > cq[0].commit) begin
        check("commit_seen", 32'd0, 32'd1);
        void'(cq.pop_front());
      end
      if (fl != 6'd0) begin
        if (cq.size() == 0) begin
          check("unexpected_commit", {26'd0, fl}, 32'd0);
        end else begin
          exp_t e;
          red_t r;
          e = cq.pop_front();
          check("commit_cyc", cyc, e.commit);
          check("flags", {26'd0, fl}, {26'd0, e.flags});
          check("exc_pc", exc_pc, e.pc);
          check("delayslot", {31'd0, ds}, {31'd0, e.ds});
          check("commit_flush", {31'd0, flush}, 32'd1);
          check("commit_busy", {31'd0, busy}, 32'd1);
          r.target = e.target;
          r.commit = e.commit;
          r.redir  = e.commit + 1 + FC;
          rq.push_back(r);
        end
      end
      if (rq.size() > 0 && cyc > rq[0].commit && cyc < rq[0].redir) begin
        check("flush_window", {31'd0, flush}, 32'd1);
        check("flush_flags", {26'd0, fl}, 32'd0);
      end
      if (rq.size() > 0 && cyc > rq[0].redir) begin
        check("redirect_seen", 32'd0, 32'd1);
        void'(rq.pop_front());
      end
      if (redirect) begin
        if (rq.size() == 0) begin
          check("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          red_t r;
          r = rq.pop_front();
          check("redirect_cyc", cyc, r.redir);
          check("redirect_pc", redirect_pc, r.target);
          check("redirect_flush", {31'd0, flush}, 32'd0);
          $display("TXN commit@%0d redirect@%0d target=%h", r.commit, cyc, redirect_pc);
        end
      end
    end
  end

  task automatic send(input logic [4:0] exc, input logic er, input logic [31:0] pc, input logic dsl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] epc);
    exp_t e;
    @(negedge clk);
    mem_valid = 1'b1; mem_exc = exc; mem_eret = er; mem_pc = pc; mem_delayslot = dsl;
    wb_we = we; wb_waddr = wa; wb_wdata = wd; cp0_epc = epc;
    e.flags  = exp_flags(exc, er);
    e.pc     = pc;
    e.ds     = (exc != 5'd0) ? dsl : 1'b0;
    e.target = exp_target(exc, we, wa, wd, epc);
    e.commit = cyc + 1;
    cq.push_back(e);
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = 5'd0; mem_eret = 1'b0; wb_we = 1'b0;
    repeat (FC + 4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    exp_t e;
    rst = 1'b1; rst4 = 1'b1;
    mem_valid = 1'b0; v4 = 1'b0; mem_delayslot = 1'b0; mem_eret = 1'b0; stall = 1'b0;
    wb_we = 1'b0; timer = 1'b0; mem_pc = 32'd0; wb_wdata = 32'd0; cp0_epc = 32'd0;
    mem_exc = 5'd0; wb_waddr = 5'd0; hw_int = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_flags", {25'd0, brk, sys, ovf, ades, adel, eret, ds}, 32'd0);
    check("rst_exc_pc", exc_pc, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_ctrl", {29'd0, flush, redirect, busy}, 32'd0);
    check("rst_int", {26'd0, int_o}, 32'd0);
    rst = 1'b0; rst4 = 1'b0;
    mon_en = 1'b1;

    // Syscall, priority, eret forwarded/not, exception beating eret, ades.
    send(5'b01000, 1'b0, 32'h80001000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    send(5'b11100, 1'b0, 32'h80000010, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    send(5'b00000, 1'b1, 32'h80000500, 1'b1, 1'b1, 5'd14, 32'h80002000, 32'h80000000);
    send(5'b00000, 1'b1, 32'h80000504, 1'b0, 1'b1, 5'd13, 32'h80002000, 32'h80000040);
    send(5'b00001, 1'b1, 32'h80000600, 1'b1, 1'b1, 5'd14, 32'h80002000, 32'h80000000);
    send(5'b00010, 1'b0, 32'h80000700, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // Overflow held off by a 3-cycle stall, then an adel offered while busy.
    @(negedge clk);
    mem_valid = 1'b1; mem_exc = 5'b00100; mem_pc = 32'h80000100; mem_delayslot = 1'b0; stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    e.flags = 6'b001000; e.pc = 32'h80000100; e.ds = 1'b0; e.target = VEC; e.commit = cyc + 1;
    cq.push_back(e);
    @(negedge clk);
    mem_exc = 5'b00001; mem_pc = 32'h80000200;
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b0; mem_exc = 5'd0;
    repeat (6) @(negedge clk);

    // Interrupt synchroniser and combinational timer path.
    hw_int = 6'b000100;
    @(negedge clk);
    check("int_one_edge", {26'd0, int_o}, 32'd0);
    @(negedge clk);
    check("int_two_edges", {26'd0, int_o}, 32'h4);
    timer = 1'b1;
    #1;
    check("timer_int", {31'd0, int_o[5]}, 32'd1);
    timer = 1'b0;
    #1;
    check("timer_int_off", {31'd0, int_o[5]}, 32'd0);
    hw_int = 6'd0;
    repeat (3) @(negedge clk);

    // Reset mid-FLUSH on the FLUSH_CYCLES=4 instance.
    v4 = 1'b1; mem_exc = 5'b01000; mem_pc = 32'h80003000;
    @(negedge clk);
    v4 = 1'b0; mem_exc = 5'd0;
    check("d4_commit", {31'd0, d4_sys}, 32'd1);
    @(negedge clk);
    check("d4_in_flush", {30'd0, d4_flush, d4_busy}, 32'd3);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    check("d4_rst_flags", {25'd0, d4_brk, d4_sys, d4_ovf, d4_ades, d4_adel, d4_eret, d4_ds}, 32'd0);
    check("d4_rst_ctrl", {29'd0, d4_flush, d4_redirect, d4_busy}, 32'd0);
    check("d4_rst_pcs", d4_exc_pc | d4_redirect_pc, 32'd0);
    check("d4_rst_int", {26'd0, d4_int}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | d4_redirect | d4_busy;
    end
    check("d4_no_redirect", {31'd0, seen}, 32'd0);

    check("queues_drained", cq.size() + rq.size(), 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
